// File: rtl/bus_grant_scheduler.sv
// Memory-bus grant scheduler: one-hot registered grant held for a whole transaction, with unused-grant reclaim.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module bus_grant_scheduler #(
  parameter int NUM_REQ        = 6,
  parameter int IDX_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int CNT_WIDTH      = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   in_reqcyc,
  input  logic                 in_bus_busy,
  output logic [NUM_REQ-1:0]   out_grant,
  output logic                 out_owner_valid,
  output logic [IDX_WIDTH-1:0] out_owner_id,
  output logic                 out_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] wd_q, wd_d;
  logic [IDX_WIDTH-1:0] last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [IDX_WIDTH-1:0] owner_id_q, owner_id_d;
  logic                 timeout_q, timeout_d;

  logic                 win_found;
  logic [IDX_WIDTH-1:0] win_idx;

`ifdef ARB_ROUND_ROBIN_EN
  // Search starts just after the previous owner and wraps, so nobody is served twice per round.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_owner_q) + k) % NUM_REQ;
      if (!win_found && in_reqcyc[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(cand);
      end
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && in_reqcyc[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    valid_d      = valid_q;
    owner_id_d   = owner_id_q;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Busy while idle is left-over activity from the previous owner; wait it out.
        if (!in_bus_busy && win_found) begin
          state_d           = S_GRANT;
          grant_d           = '0;
          grant_d[win_idx]  = 1'b1;
          valid_d           = 1'b1;
          owner_id_d        = win_idx;
          wd_d              = '0;
        end
      end
      S_GRANT: begin
        if (in_bus_busy) begin
          state_d = S_BUSY;
        end else if (!in_reqcyc[owner_id_q]) begin
          state_d = S_RELEASE;
          grant_d = '0;
          valid_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_RELEASE;
          grant_d   = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (!in_bus_busy) begin
          state_d = S_RELEASE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      S_RELEASE: begin
        last_owner_d = owner_id_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wd_q         <= '0;
      last_owner_q <= IDX_WIDTH'(NUM_REQ - 1);
      grant_q      <= '0;
      valid_q      <= 1'b0;
      owner_id_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      valid_q      <= valid_d;
      owner_id_q   <= owner_id_d;
      timeout_q    <= timeout_d;
    end
  end

  assign out_grant       = grant_q;
  assign out_owner_valid = valid_q;
  assign out_owner_id    = owner_id_q;
  assign out_timeout     = timeout_q;

endmodule
